// File: rtl/cache_def.sv
// Shared types and constants for the direct-mapped write-back cache controller.
// Tags are stored in a field wide enough for any legal line count; unused upper
// bits are simply zero.
package cache_def;

  localparam int unsigned OFFSET_W      = 4;     // byte offset inside a 128-bit block
  localparam int unsigned DEF_NUM_LINES = 1024;
  localparam int unsigned TAG_MSB       = 31;
  localparam int unsigned TAG_LSB       = OFFSET_W + $clog2(DEF_NUM_LINES);
  localparam int unsigned TAG_W_MAX     = 32 - OFFSET_W;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;      // 1 = write
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_W_MAX-1:0] tag;
  } cache_tag_type;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE_TAG,
    ALLOCATE,
    WRITE_BACK
  } cache_state_e;

  // Extract 32-bit word 'sel' from a block.
  function automatic logic [31:0] get_word(input cache_data_type line, input logic [1:0] sel);
    return line[32*sel +: 32];
  endfunction

  // Return 'line' with word 'sel' replaced by 'word'.
  function automatic cache_data_type put_word(input cache_data_type line, input logic [1:0] sel,
                                              input logic [31:0] word);
    cache_data_type r;
    r = line;
    r[32*sel +: 32] = word;
    return r;
  endfunction

endpackage

// File: rtl/dm_cache_data.sv
// Tag + data storage for the direct-mapped cache: asynchronous read, one
// synchronous write port, valid/dirty bits cleared by synchronous reset.
module dm_cache_data
  import cache_def::*;
#(
  parameter  int unsigned NUM_LINES = 1024,
  localparam int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [IDX_W-1:0] idx_i,
  output cache_tag_type  tag_rd_o,
  output cache_data_type data_rd_o,
  input  logic           we_i,
  input  cache_tag_type  tag_wr_i,
  input  cache_data_type data_wr_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W_MAX-1:0] tag_mem_q  [NUM_LINES];
  cache_data_type       data_mem_q [NUM_LINES];

  // Status bits: wiped as a whole on reset, otherwise updated with the line.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= tag_wr_i.valid;
      dirty_q[idx_i] <= tag_wr_i.dirty;
    end
  end

  // Tag and block storage.
  // NOTE: no reset on the arrays; the valid bits qualify every read, so contents can stay undefined.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_mem_q[idx_i]  <= tag_wr_i.tag;
      data_mem_q[idx_i] <= data_wr_i;
    end
  end

  assign tag_rd_o  = '{valid: valid_q[idx_i], dirty: dirty_q[idx_i], tag: tag_mem_q[idx_i]};
  assign data_rd_o = data_mem_q[idx_i];

endmodule

// File: rtl/dm_cache_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller (memory initiator).
// Optional build macro CACHE_STATS_EN adds wrapping hit/miss counters
// (hit_cnt_o, miss_cnt_o).
module dm_cache_fsm
  import cache_def::*;
#(
  parameter int unsigned NUM_LINES = 1024
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  cpu_req_type    cpu_req_i,
  output cpu_result_type cpu_res_o,
  output mem_req_type    mem_req_o,
  input  mem_data_type   mem_data_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]    hit_cnt_o,
  output logic [31:0]    miss_cnt_o
`endif
);

  localparam int unsigned IDX_W   = $clog2(NUM_LINES);
  localparam int unsigned TAG_LSB_L = OFFSET_W + IDX_W;

  cache_state_e   state_q;
  cpu_req_type    req_q;
  mem_req_type    mem_req_q;
  logic           first_q;      // first cycle in WRITE_BACK/ALLOCATE: ready is stale

  logic [IDX_W-1:0]     idx;
  logic [TAG_W_MAX-1:0] req_tag;
  logic [1:0]           word_sel;
  cache_tag_type        tag_rd;
  cache_data_type       data_rd;
  logic                 hit;
  logic                 mem_accept;
  logic                 line_we_d;
  cache_tag_type        line_tag_d;
  cache_data_type       line_data_d;

  function automatic logic [31:0] block_addr(input logic [TAG_W_MAX-1:0] tag,
                                             input logic [IDX_W-1:0] index);
    return (32'(tag) << TAG_LSB_L) | (32'(index) << OFFSET_W);
  endfunction

  assign idx        = req_q.addr[TAG_LSB_L-1:OFFSET_W];
  assign req_tag    = TAG_W_MAX'(req_q.addr >> TAG_LSB_L);
  assign word_sel   = req_q.addr[3:2];
  assign hit        = tag_rd.valid && (tag_rd.tag == req_tag);
  assign mem_accept = mem_data_i.ready && !first_q;

  // Byte-select bits and the latched valid flag carry no information here.
  logic unused_req;
  assign unused_req = ^{req_q.addr[1:0], req_q.valid};

  dm_cache_data #(.NUM_LINES(NUM_LINES)) u_data (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .idx_i     (idx),
    .tag_rd_o  (tag_rd),
    .data_rd_o (data_rd),
    .we_i      (line_we_d),
    .tag_wr_i  (line_tag_d),
    .data_wr_i (line_data_d)
  );

  // Line update: write hit merges the CPU word, accepted refill loads the block.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    line_we_d   = 1'b0;
    line_tag_d  = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
    line_data_d = mem_data_i.data;
    if (state_q == COMPARE_TAG && hit && req_q.rw) begin
      line_we_d        = 1'b1;
      line_tag_d.dirty = 1'b1;
      line_data_d      = put_word(data_rd, word_sel, req_q.data);
    end else if (state_q == ALLOCATE && mem_accept) begin
      line_we_d = 1'b1;
    end
  end

  // CPU response exists only during a hit in COMPARE_TAG.
  always_comb begin
    cpu_res_o = '0;
    if (state_q == COMPARE_TAG && hit) begin
      cpu_res_o.ready = 1'b1;
      cpu_res_o.data  = get_word(data_rd, word_sel);
    end
  end

  // Controller FSM with registered memory request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= '0;
      mem_req_q <= '0;
      first_q   <= 1'b0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req_i.valid) begin
            req_q   <= cpu_req_i;
            state_q <= COMPARE_TAG;
          end
        end
        COMPARE_TAG: begin
          if (hit) begin
            state_q <= IDLE;
          end else if (tag_rd.valid && tag_rd.dirty) begin
            state_q   <= WRITE_BACK;
            first_q   <= 1'b1;
            mem_req_q <= '{addr: block_addr(tag_rd.tag, idx), data: data_rd, rw: 1'b1, valid: 1'b1};
          end else begin
            state_q   <= ALLOCATE;
            first_q   <= 1'b1;
            mem_req_q <= '{addr: block_addr(req_tag, idx), data: '0, rw: 1'b0, valid: 1'b1};
          end
        end
        WRITE_BACK: begin
          if (mem_accept) begin
            state_q   <= ALLOCATE;
            first_q   <= 1'b1;
            mem_req_q <= '{addr: block_addr(req_tag, idx), data: '0, rw: 1'b0, valid: 1'b1};
          end
        end
        ALLOCATE: begin
          if (mem_accept) begin
            state_q   <= COMPARE_TAG;
            mem_req_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o = mem_req_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        refilled_q;   // current access has already been refilled

  // Hit/miss statistics; a hit that follows a refill belongs to the miss.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refilled_q <= 1'b0;
    end else begin
      if (state_q == ALLOCATE && mem_accept) begin
        refilled_q <= 1'b1;
      end else if (state_q == IDLE) begin
        refilled_q <= 1'b0;
      end
      if (state_q == COMPARE_TAG) begin
        if (hit && !refilled_q) begin
          hit_cnt_q <= hit_cnt_q + 32'd1;
        end else if (!hit) begin
          miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
